// File: rtl/piccolo_io_frontend.sv
`default_nettype none
// ---------------------------------------------------------------------------
// piccolo_io_frontend : word-serial load / run / unload wrapper for Piccolo
// Optional key reuse across frames: define PICCOLO_KEY_REUSE_EN
// Revision 1.0
// ---------------------------------------------------------------------------
module piccolo_io_frontend #(
   parameter int ROUNDS80  = 25,
   parameter int ROUNDS128 = 31
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         version,
   input  logic [0:15]  din,
   input  logic         din_valid,
   output logic         din_ready,
   output logic [0:63]  ct,
   output logic         ct_valid,
   input  logic         ct_ready,
`ifdef PICCOLO_KEY_REUSE_EN
   input  logic         reuse_key,
`endif
   output logic         core_reset,
   output logic         core_version,
   output logic [0:127] core_key,
   output logic [0:63]  core_pt,
   input  logic [0:63]  core_ct
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_LOAD_KEY = 3'd1;
   localparam logic [2:0] ST_LOAD_PT  = 3'd2;
   localparam logic [2:0] ST_START    = 3'd3;
   localparam logic [2:0] ST_RUN      = 3'd4;
   localparam logic [2:0] ST_DONE     = 3'd5;

   // Two rounds per clock plus the initial whitening cycle.
   localparam logic [3:0] LAT80  = 4'((ROUNDS80 - 1) / 2);
   localparam logic [3:0] LAT128 = 4'((ROUNDS128 - 1) / 2);

   logic [2:0] state;
   logic [2:0] word_cnt;
   logic [3:0] cnt;
   logic       take;
   logic       key_last;
   logic       pt_last;
   logic [3:0] lat;
   logic       skip_key;
   logic [6:0] key_base;
   logic [5:0] pt_base;

   assign din_ready  = (state == ST_LOAD_KEY) || (state == ST_LOAD_PT);
   assign take       = din_valid & din_ready;
   assign ct_valid   = (state == ST_DONE);
   assign core_reset = (state == ST_START);
   // word_cnt==0 never matches either terminal count, so the stale version is harmless there.
   assign key_last   = core_version ? (word_cnt == 3'd7) : (word_cnt == 3'd4);
   assign pt_last    = (word_cnt == 3'd3);
   assign lat        = core_version ? LAT128 : LAT80;
   assign key_base   = {word_cnt, 4'b0000};
   assign pt_base    = {word_cnt[1:0], 4'b0000};

`ifdef PICCOLO_KEY_REUSE_EN
   logic key_loaded;

   assign skip_key = reuse_key & key_loaded;

   always_ff @(posedge clk) begin
      if (reset) begin
         key_loaded <= 1'b0;
      end else if ((state == ST_LOAD_KEY) && take && key_last) begin
         key_loaded <= 1'b1;
      end
   end
`else
   assign skip_key = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         word_cnt     <= 3'd0;
         cnt          <= 4'd0;
         ct           <= '0;
         core_key     <= '0;
         core_pt      <= '0;
         core_version <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               word_cnt <= 3'd0;
               state    <= skip_key ? ST_LOAD_PT : ST_LOAD_KEY;
            end
            ST_LOAD_KEY: begin
               if (take) begin
                  // First word also clears the tail so an 80-bit key leaves [80:127] zero.
                  if (word_cnt == 3'd0) begin
                     core_version <= version;
                     core_key     <= {din, 112'b0};
                  end else begin
                     core_key[key_base +: 16] <= din;
                  end
                  if (key_last) begin
                     word_cnt <= 3'd0;
                     state    <= ST_LOAD_PT;
                  end else begin
                     word_cnt <= word_cnt + 3'd1;
                  end
               end
            end
            ST_LOAD_PT: begin
               if (take) begin
                  core_pt[pt_base +: 16] <= din;
                  if (pt_last) begin
                     word_cnt <= 3'd0;
                     state    <= ST_START;
                  end else begin
                     word_cnt <= word_cnt + 3'd1;
                  end
               end
            end
            ST_START: begin
               cnt   <= 4'd0;
               state <= ST_RUN;
            end
            ST_RUN: begin
               if (cnt == lat) begin
                  ct    <= core_ct;
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            ST_DONE: begin
               if (ct_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_piccolo_io_frontend.sv
`default_nettype none
// tb_piccolo_io_frontend : directed self-checking bench; the core is modelled by
// driving core_ct with the golden value only in the cycle the capture must happen.
module tb_piccolo_io_frontend;

   logic         clk = 1'b0;
   logic         reset;
   logic         version;
   logic [0:15]  din;
   logic         din_valid;
   logic         din_ready;
   logic [0:63]  ct;
   logic         ct_valid;
   logic         ct_ready;
   logic         core_reset;
   logic         core_version;
   logic [0:127] core_key;
   logic [0:63]  core_pt;
   logic [0:63]  core_ct;
`ifdef PICCOLO_KEY_REUSE_EN
   logic         reuse_key;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [127:0] K80  = 128'h0011_2233_4455_6677_8899_0000_0000_0000;
   localparam logic [127:0] K128 = 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff;
   localparam logic [63:0]  PT   = 64'h0123_4567_89ab_cdef;
   localparam logic [63:0]  PT2  = 64'hfedc_ba98_7654_3210;
   localparam logic [63:0]  G80  = 64'h8d2b_ff99_35f8_4056;
   localparam logic [63:0]  G128 = 64'h5ba1_c3d2_e4f0_1179;
   localparam logic [63:0]  G2   = 64'h0f1e_2d3c_4b5a_6978;

   always #5 clk = ~clk;

   piccolo_io_frontend dut (
      .clk          (clk),
      .reset        (reset),
      .version      (version),
      .din          (din),
      .din_valid    (din_valid),
      .din_ready    (din_ready),
      .ct           (ct),
      .ct_valid     (ct_valid),
      .ct_ready     (ct_ready),
`ifdef PICCOLO_KEY_REUSE_EN
      .reuse_key    (reuse_key),
`endif
      .core_reset   (core_reset),
      .core_version (core_version),
      .core_key     (core_key),
      .core_pt      (core_pt),
      .core_ct      (core_ct)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Offers one word (optionally after an idle cycle); returns 1 ns after the accept edge.
   task automatic send(input logic [15:0] w, input bit gap);
      int n;
      n = 0;
      if (gap) begin
         din_valid = 1'b0;
         din       = 16'hffff;
         @(posedge clk); #1;
      end
      din       = w;
      din_valid = 1'b1;
      while (!din_ready && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("din_ready_wait", 128'(din_ready), 128'd1);
      @(posedge clk); #1;
      din_valid = 1'b0;
      din       = 16'hffff;
   endtask

   task automatic load(input logic v, input logic [127:0] k, input int nkw,
                       input logic [63:0] p, input bit gap);
      version = v;
      for (int i = 0; i < nkw; i++) begin
         send(k[127 - 16*i -: 16], gap);
         version = ~v;
      end
      for (int i = 0; i < 4; i++) begin
         send(p[63 - 16*i -: 16], gap);
      end
   endtask

   // Called 1 ns after the last plaintext accept edge E0; ct_valid must rise at E0+lat.
   task automatic finish(input logic [63:0] gold, input int lat, input int hold,
                         input logic [127:0] ek, input logic [63:0] ep, input logic ev);
      chk("core_reset_start", 128'(core_reset), 128'd1);
      chk("din_ready_start", 128'(din_ready), 128'd0);
      ct_ready = (hold == 0);
      for (int k = 1; k <= lat; k++) begin
         core_ct = (k == lat) ? gold : ~gold;
         @(posedge clk); #1;
         chk("ct_valid_latency", 128'(ct_valid), 128'(k == lat));
         chk("core_reset_run", 128'(core_reset), 128'd0);
      end
      core_ct = 64'h0;
      chk("ct", 128'(ct), 128'(gold));
      chk("core_key", core_key, ek);
      chk("core_pt", 128'(core_pt), 128'(ep));
      chk("core_version", 128'(core_version), 128'(ev));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk("ct_valid_hold", 128'(ct_valid), 128'd1);
         chk("ct_hold", 128'(ct), 128'(gold));
         chk("din_ready_hold", 128'(din_ready), 128'd0);
      end
      ct_ready = 1'b1;
      @(posedge clk); #1;
      chk("ct_valid_drop", 128'(ct_valid), 128'd0);
      ct_ready = 1'b0;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_din_ready", 128'(din_ready), 128'd0);
      chk("rst_ct_valid", 128'(ct_valid), 128'd0);
      chk("rst_core_reset", 128'(core_reset), 128'd0);
      chk("rst_ct", 128'(ct), 128'd0);
      chk("rst_core_key", core_key, 128'd0);
      chk("rst_core_pt", 128'(core_pt), 128'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      version   = 1'b0;
      din       = 16'h0;
      din_valid = 1'b0;
      ct_ready  = 1'b0;
      core_ct   = 64'h0;
`ifdef PICCOLO_KEY_REUSE_EN
      reuse_key = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs();
      reset = 1'b0;

      // Piccolo-80 reference frame.
      load(1'b0, K80, 5, PT, 1'b0);
      finish(G80, 14, 0, K80, PT, 1'b0);

      // Piccolo-128 with a stalled consumer in DONE.
      load(1'b1, K128, 8, PT, 1'b0);
      finish(G128, 17, 20, K128, PT, 1'b1);

      // Idle cycles between words; 80-bit key after 128-bit must leave [80:127] zero.
      load(1'b0, K80, 5, PT2, 1'b1);
      finish(G2, 14, 0, K80, PT2, 1'b0);

      // Reset while RUN holds cnt=6.
      load(1'b1, K128, 8, PT, 1'b0);
      repeat (7) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk_reset_outputs();
      reset     = 1'b0;
      din_valid = 1'b1;
      din       = 16'hffff;
      chk("idle_din_ready", 128'(din_ready), 128'd0);
      @(posedge clk); #1;
      din_valid = 1'b0;
      chk("post_rst_core_reset", 128'(core_reset), 128'd0);
      chk("post_rst_ct_valid", 128'(ct_valid), 128'd0);
      load(1'b0, K80, 5, PT, 1'b0);
      finish(G80, 14, 0, K80, PT, 1'b0);

`ifdef PICCOLO_KEY_REUSE_EN
      // Reuse the Piccolo-80 key just loaded: only plaintext words are sent.
      reuse_key = 1'b1;
      load(1'b1, K128, 0, PT2, 1'b0);
      finish(G2, 14, 0, K80, PT2, 1'b0);

      // After reset no key is held, so reuse_key must fall back to a full load.
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      load(1'b1, K128, 8, PT, 1'b0);
      finish(G128, 17, 0, K128, PT, 1'b1);
      reuse_key = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
